// File: rtl/ib_ram_page_loader.sv
// ib_ram_page_loader
// Loads one full frame of LUT pages into the IB-RAM. Each accepted beat on
// lut_data_in becomes one registered write at {frame, page}. A frame is PAGE_NUM
// pages, and the loader never writes into the frame the CNU is currently reading.
//
// Ports
//   write_clk         sole clock, rising edge
//   rst               asynchronous active-high reset
//   load_start        request to load one frame (accepted only in IDLE)
//   load_frame_sel    target frame, sampled when load_start is accepted
//   read_addr_offset  frame currently being read by the CNU
//   load_abort        cancels a load in progress
//   lut_data_in       page payload, bank0 in the upper bits, bank1 in the lower bits
//   lut_data_valid    lut_data_in is valid this cycle
//   lut_data_ready    loader takes a beat this cycle (state == LOAD)
//   page_addr_ram     registered write address {frame, page}
//   ram_write_data_0  registered write data
//   ib_ram_we         registered write enable
//   load_busy         high while loading
//   load_done         one-cycle pulse on completion, aligned with the last write
//   load_err          one-cycle pulse when a load_start is rejected
module ib_ram_page_loader #(
    parameter int unsigned ENTRY_ADDR    = 6,
    parameter int unsigned LUT_PORT_SIZE = 3,
    parameter int unsigned BANK_NUM      = 2,
    localparam int unsigned PAGE_W       = ENTRY_ADDR - 1,
    localparam int unsigned PAGE_NUM     = 1 << PAGE_W,
    localparam int unsigned DW           = LUT_PORT_SIZE * BANK_NUM
) (
    input  logic                  write_clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_frame_sel,
    input  logic                  read_addr_offset,
    input  logic                  load_abort,
    input  logic [DW-1:0]         lut_data_in,
    input  logic                  lut_data_valid,
    output logic                  lut_data_ready,
    output logic [ENTRY_ADDR-1:0] page_addr_ram,
    output logic [DW-1:0]         ram_write_data_0,
    output logic                  ib_ram_we,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGE_NUM - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state;
    logic [PAGE_W-1:0] page_cnt;
    logic              frame_q;

    // Ready depends on state only, so an upstream source never sees a
    // combinational path back from its own valid.
    assign lut_data_ready = (state == StLoad);
    assign load_busy      = (state == StLoad);

    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            page_cnt         <= '0;
            frame_q          <= 1'b0;
            page_addr_ram    <= '0;
            ram_write_data_0 <= '0;
            ib_ram_we        <= 1'b0;
            load_done        <= 1'b0;
            load_err         <= 1'b0;
        end else begin
            // Pulsed outputs default low; address and data hold.
            ib_ram_we <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Abort wins over start even though it has nothing to cancel.
                    if (load_start && !load_abort) begin
                        if (load_frame_sel != read_addr_offset) begin
                            frame_q  <= load_frame_sel;
                            page_cnt <= '0;
                            state    <= StLoad;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (load_abort) begin
                        // A beat offered alongside abort is dropped.
                        state <= StIdle;
                    end else if (lut_data_valid) begin
                        ib_ram_we        <= 1'b1;
                        page_addr_ram    <= {frame_q, page_cnt};
                        ram_write_data_0 <= lut_data_in;
                        page_cnt         <= page_cnt + PAGE_W'(1);
                        if (page_cnt == LAST_PAGE) begin
                            load_done <= 1'b1;
                            state     <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ib_ram_page_loader.sv
module tb_ib_ram_page_loader;

    logic       write_clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       load_frame_sel = 1'b0;
    logic       read_addr_offset = 1'b0;
    logic       load_abort = 1'b0;
    logic [5:0] lut_data_in = '0;
    logic       lut_data_valid = 1'b0;
    logic       lut_data_ready;
    logic [5:0] page_addr_ram;
    logic [5:0] ram_write_data_0;
    logic       ib_ram_we;
    logic       load_busy;
    logic       load_done;
    logic       load_err;

    int total = 0;
    int bad   = 0;

    ib_ram_page_loader dut (
        .write_clk        (write_clk),
        .rst              (rst),
        .load_start       (load_start),
        .load_frame_sel   (load_frame_sel),
        .read_addr_offset (read_addr_offset),
        .load_abort       (load_abort),
        .lut_data_in      (lut_data_in),
        .lut_data_valid   (lut_data_valid),
        .lut_data_ready   (lut_data_ready),
        .page_addr_ram    (page_addr_ram),
        .ram_write_data_0 (ram_write_data_0),
        .ib_ram_we        (ib_ram_we),
        .load_busy        (load_busy),
        .load_done        (load_done),
        .load_err         (load_err)
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(ib_ram_we), 0);
        chk({tag, "_addr"},  32'(page_addr_ram), 0);
        chk({tag, "_data"},  32'(ram_write_data_0), 0);
        chk({tag, "_done"},  32'(load_done), 0);
        chk({tag, "_err"},   32'(load_err), 0);
        chk({tag, "_ready"}, 32'(lut_data_ready), 0);
        chk({tag, "_busy"},  32'(load_busy), 0);
    endtask

    int writes;
    int dones;

    initial begin
        // Reset state.
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // Full load into frame 1 while frame 0 is being read.
        read_addr_offset = 1'b0;
        load_frame_sel   = 1'b1;
        load_start       = 1'b1;
        tick();
        load_start = 1'b0;
        chk("full_busy", 32'(load_busy), 1);
        chk("full_ready", 32'(lut_data_ready), 1);
        chk("full_no_we_yet", 32'(ib_ram_we), 0);
        dones = 0;
        for (int i = 0; i < 32; i++) begin
            lut_data_valid = 1'b1;
            lut_data_in    = 6'(i);
            // Read offset moving mid-load must not change the latched frame.
            if (i == 16) read_addr_offset = 1'b1;
            tick();
            chk("full_we", 32'(ib_ram_we), 1);
            chk("full_addr", 32'(page_addr_ram), 32'h20 + 32'(i));
            chk("full_data", 32'(ram_write_data_0), 32'(i));
            chk("full_done", 32'(load_done), (i == 31) ? 1 : 0);
            chk("full_ready_after", 32'(lut_data_ready), (i == 31) ? 0 : 1);
        end
        // Extra data: valid stays high after the last beat.
        lut_data_in = 6'h2A;
        tick();
        chk("extra_we", 32'(ib_ram_we), 0);
        chk("extra_ready", 32'(lut_data_ready), 0);
        chk("extra_done", 32'(load_done), 0);
        chk("extra_addr_hold", 32'(page_addr_ram), 32'h3F);
        chk("extra_data_hold", 32'(ram_write_data_0), 31);
        tick();
        chk("extra_we2", 32'(ib_ram_we), 0);
        lut_data_valid = 1'b0;
        read_addr_offset = 1'b0;

        // Collision: target frame equals the frame being read.
        read_addr_offset = 1'b1;
        load_frame_sel   = 1'b1;
        load_start       = 1'b1;
        tick();
        load_start = 1'b0;
        chk("coll_err", 32'(load_err), 1);
        chk("coll_we", 32'(ib_ram_we), 0);
        chk("coll_busy", 32'(load_busy), 0);
        tick();
        chk("coll_err_once", 32'(load_err), 0);
        chk("coll_busy2", 32'(load_busy), 0);

        // Gapped valid into frame 0.
        read_addr_offset = 1'b1;
        load_frame_sel   = 1'b0;
        load_start       = 1'b1;
        tick();
        load_start = 1'b0;
        writes = 0;
        for (int c = 0; c < 64; c++) begin
            lut_data_valid = (c % 2 == 0);
            lut_data_in    = 6'(c / 2);
            tick();
            if (ib_ram_we) writes++;
            if (c % 2 == 0) begin
                chk("gap_we", 32'(ib_ram_we), 1);
                chk("gap_addr", 32'(page_addr_ram), 32'(c / 2));
                chk("gap_data", 32'(ram_write_data_0), 32'(c / 2));
            end else begin
                chk("gap_idle_we", 32'(ib_ram_we), 0);
            end
        end
        lut_data_valid = 1'b0;
        chk("gap_writes", 32'(writes), 32);
        chk("gap_busy_end", 32'(load_busy), 0);

        // Abort after 10 beats, with a beat offered in the abort cycle.
        read_addr_offset = 1'b0;
        load_frame_sel   = 1'b1;
        load_start       = 1'b1;
        tick();
        load_start = 1'b0;
        writes = 0;
        dones  = 0;
        for (int i = 0; i < 10; i++) begin
            lut_data_valid = 1'b1;
            lut_data_in    = 6'(i + 3);
            tick();
            if (ib_ram_we) writes++;
            chk("abort_addr", 32'(page_addr_ram), 32'h20 + 32'(i));
        end
        load_abort  = 1'b1;
        lut_data_in = 6'h15;
        tick();
        load_abort = 1'b0;
        lut_data_valid = 1'b0;
        chk("abort_we", 32'(ib_ram_we), 0);
        chk("abort_done", 32'(load_done), 0);
        chk("abort_busy", 32'(load_busy), 0);
        chk("abort_data_hold", 32'(ram_write_data_0), 12);
        chk("abort_writes", 32'(writes), 10);
        tick();
        chk("abort_idle_done", 32'(load_done), 0);

        // New load restarts at page 0; reset after 5 beats.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lut_data_valid = 1'b1;
            lut_data_in    = 6'(i + 7);
            tick();
            chk("restart_addr", 32'(page_addr_ram), 32'h20 + 32'(i));
            chk("restart_data", 32'(ram_write_data_0), 32'(i + 7));
        end
        chk("pre_rst_we", 32'(ib_ram_we), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        dones = 0;
        writes = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (load_done) dones++;
            if (ib_ram_we) writes++;
        end
        lut_data_valid = 1'b0;
        chk("rst_no_done", 32'(dones), 0);
        chk("rst_no_we", 32'(writes), 0);
        chk("rst_busy", 32'(load_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
